ioctl_ram_writer: RTL

// - Downstream of the SPI file-download stage. Takes its 16-bit word stream
//   (ioctl_download/ioctl_we/ioctl_addr/ioctl_dout) and writes each word into

---
 rtl/ioctl_ram_writer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ioctl_ram_writer.sv
// ioctl_ram_writer: queues ioctl download words and writes them to RAM over a req/ack port
module ioctl_ram_writer #(
    parameter int FIFO_AW = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ioctl_download,
    input  logic [7:0]       ioctl_index,
    input  logic             ioctl_we,
    input  logic [24:0]      ioctl_addr,
    input  logic [15:0]      ioctl_dout,
    output logic             mem_wr,
    output logic [23:0]      mem_addr,
    output logic [15:0]      mem_din,
    input  logic             mem_ack,
    output logic             cpu_hold,
    output logic             done,
    output logic [7:0]       done_index,
    output logic             overflow,
    output logic [CNT_W-1:0] word_count
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [39:0]      fifo_q [DEPTH];
    logic [39:0]      fifo_d [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             we_dly_q, we_dly_d, dl_dly_q, dl_dly_d;
    logic [1:0]       state_q, state_d;
    logic             mem_wr_q, mem_wr_d;
    logic [23:0]      mem_addr_q, mem_addr_d;
    logic [15:0]      mem_din_q, mem_din_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             done_q, done_d;
    logic [7:0]       done_index_q, done_index_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             empty, full, push, pop, accept, dl_rise, dl_fall, finish;
    logic [39:0]      head;
    logic             addr_unused;

    assign addr_unused = ioctl_addr[0];
    assign empty   = wr_ptr_q == rd_ptr_q;
    assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign push    = ioctl_we & ~we_dly_q;
    assign pop     = ~mem_wr_q & ~empty;
    // a pop on the same edge frees the slot the push reuses, so full+pop still accepts
    assign accept  = push & (~full | pop);
    assign dl_rise = ioctl_download & ~dl_dly_q;
    assign dl_fall = ~ioctl_download & dl_dly_q;
    assign head    = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
    assign finish  = (state_q == S_DRAIN) & ~dl_rise & empty & ~mem_wr_q;

    // next-state for FIFO, memory request, sequencing and status
    always_comb begin
        fifo_d = fifo_q;
        if (accept) fifo_d[wr_ptr_q[FIFO_AW-1:0]] = {ioctl_addr[24:1], ioctl_dout};
        wr_ptr_d     = wr_ptr_q + (FIFO_AW+1)'(accept);
        rd_ptr_d     = rd_ptr_q + (FIFO_AW+1)'(pop);
        we_dly_d     = ioctl_we;
        dl_dly_d     = ioctl_download;
        mem_wr_d     = mem_wr_q ? ~mem_ack : pop;
        mem_addr_d   = pop ? head[39:16] : mem_addr_q;
        mem_din_d    = pop ? head[15:0] : mem_din_q;
        state_d      = dl_rise ? S_LOAD :
                       (state_q == S_LOAD && dl_fall) ? S_DRAIN :
                       finish ? S_IDLE : state_q;
        cpu_hold_d   = dl_rise | (cpu_hold_q & ~finish);
        done_d       = finish;
        done_index_d = dl_rise ? ioctl_index : done_index_q;
        overflow_d   = dl_rise ? 1'b0 : overflow_q | (push & ~accept);
        word_count_d = dl_rise ? '0 :
                       (mem_wr_q & mem_ack & ~&word_count_q) ? word_count_q + CNT_W'(1) :
                       word_count_q;
    end

    // FIFO storage carries no reset; only the pointers define its contents
    always_ff @(posedge clk_sys) begin
        fifo_q <= fifo_d;
    end

    // control and output registers, flushed by reset
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            we_dly_q     <= 1'b0;
            dl_dly_q     <= 1'b0;
            state_q      <= S_IDLE;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            done_index_q <= '0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            we_dly_q     <= we_dly_d;
            dl_dly_q     <= dl_dly_d;
            state_q      <= state_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            done_index_q <= done_index_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign done_index = done_index_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;
endmodule
